// File: rtl/ptp_pkt_pkg.sv
// Shared definitions for the ptp2lcm 134-bit packet stream: flit codes,
// field positions inside metadata/frame flits, and the stamper FSM states.
package ptp_pkt_pkg;

    localparam int FLIT_W = 134;

    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_MID  = 2'b11;
    localparam logic [1:0] FLIT_TAIL = 2'b10;

    localparam logic [15:0] ETH_TYPE_PTP  = 16'h88F7;
    localparam logic [3:0]  MSG_EVENT_MAX = 4'h3;

    // Byte k of a flit occupies bits [127-8k -: 8].
    localparam int TYPE_MSB  = 133;
    localparam int TYPE_LSB  = 132;
    localparam int TS_MSB    = 127;   // flit1 bytes 0..5: ingress timestamp
    localparam int TS_LSB    = 80;
    localparam int ETYPE_MSB = 31;    // flit2 bytes 12..13: EtherType
    localparam int ETYPE_LSB = 16;
    localparam int MSG_MSB   = 11;    // flit2 byte 14 low nibble: messageType
    localparam int MSG_LSB   = 8;
    localparam int CORR_MSB  = 79;    // flit3 bytes 6..13: correctionField
    localparam int CORR_LSB  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_META1,
        ST_ETH,
        ST_CORR,
        ST_BODY
    } stamp_state_e;

    function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
        return flit[TYPE_MSB:TYPE_LSB];
    endfunction

endpackage

// File: rtl/ptp_corr_adder.sv
// Combinational residence-time correction: (temp_cnt - ingress_ts) scaled to
// ns, shifted into the 48.16 fixed-point correctionField and added mod 2^64.
module ptp_corr_adder #(
    parameter int TICK_NS = 8
) (
    input  logic [47:0] temp_cnt,
    input  logic [47:0] ingress_ts,
    input  logic [63:0] corr_in,
    output logic [63:0] corr_out
);

    localparam logic [47:0] TICK_W = 48'(TICK_NS);

    logic [47:0] resid;
    logic [47:0] scaled_ns;

    assign resid = temp_cnt - ingress_ts;
    // Only the low 48 product bits survive the <<16 into a 64-bit field.
    assign scaled_ns = resid * TICK_W;
    assign corr_out  = corr_in + {scaled_ns, 16'h0000};

endmodule

// File: rtl/ptp_residence_stamper.sv
// Transparent-clock stage: adds residence time to the correctionField of PTP
// event messages in-flight, one register stage, all other traffic unchanged.
module ptp_residence_stamper
    import ptp_pkt_pkg::*;
#(
    parameter string PLATFORM = "Xilinx",
    parameter int    TICK_NS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_data_wr,
    input  logic [FLIT_W-1:0] in_data,
    input  logic              in_data_valid,
    input  logic              in_data_valid_wr,
    output logic              in_ready,
    output logic              out_data_wr,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_data_valid,
    output logic              out_data_valid_wr,
    input  logic              out_ready,
    input  logic [47:0]       temp_cnt,
    input  logic              stamp_en,
    output logic [31:0]       stamp_cnt
);

    stamp_state_e      state_reg, state_next;
    logic [47:0]       ts_reg, ts_next;
    logic              is_ptp_reg, is_ptp_next;
    logic              stamp_fire;
    logic              discard;
    logic [1:0]        ftype;
    logic [63:0]       corr_stamped;
    logic [FLIT_W-1:0] data_next;

    assign in_ready = out_ready;
    assign ftype    = flit_type(in_data);

    // Vendor hook: a pipelined or DSP-mapped adder variant slots in here.
    generate
        if (PLATFORM == "Xilinx") begin : g_xilinx
            ptp_corr_adder #(.TICK_NS(TICK_NS)) u_corr_adder (
                .temp_cnt   (temp_cnt),
                .ingress_ts (ts_reg),
                .corr_in    (in_data[CORR_MSB:CORR_LSB]),
                .corr_out   (corr_stamped)
            );
        end else begin : g_generic
            ptp_corr_adder #(.TICK_NS(TICK_NS)) u_corr_adder (
                .temp_cnt   (temp_cnt),
                .ingress_ts (ts_reg),
                .corr_in    (in_data[CORR_MSB:CORR_LSB]),
                .corr_out   (corr_stamped)
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ts_reg     <= '0;
            is_ptp_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ts_reg     <= ts_next;
            is_ptp_reg <= is_ptp_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ts_next     = ts_reg;
        is_ptp_next = is_ptp_reg;
        stamp_fire  = 1'b0;
        discard     = 1'b0;
        if (in_data_wr) begin
            case (state_reg)
                ST_IDLE: begin
                    if (ftype == FLIT_HEAD) state_next = ST_META1;
                    else                    discard    = 1'b1;
                end
                ST_META1: begin
                    ts_next    = in_data[TS_MSB:TS_LSB];
                    state_next = ST_ETH;
                end
                ST_ETH: begin
                    is_ptp_next = (in_data[ETYPE_MSB:ETYPE_LSB] == ETH_TYPE_PTP) &&
                                  (in_data[MSG_MSB:MSG_LSB] <= MSG_EVENT_MAX) && stamp_en;
                    state_next  = ST_CORR;
                end
                ST_CORR: begin
                    // A head here belongs to a new packet and must not be stamped.
                    stamp_fire = is_ptp_reg && (ftype != FLIT_HEAD);
                    state_next = ST_BODY;
                end
                ST_BODY: state_next = ST_BODY;
                default: state_next = ST_IDLE;
            endcase
            if (ftype == FLIT_TAIL) state_next = ST_IDLE;
            if (ftype == FLIT_HEAD) state_next = ST_META1;
        end
    end

    always_comb begin
        data_next = in_data;
        if (stamp_fire) data_next[CORR_MSB:CORR_LSB] = corr_stamped;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_wr       <= 1'b0;
            out_data          <= '0;
            out_data_valid    <= 1'b0;
            out_data_valid_wr <= 1'b0;
            stamp_cnt         <= '0;
        end else begin
            out_data_wr       <= in_data_wr && !discard;
            out_data          <= data_next;
            out_data_valid    <= in_data_valid;
            out_data_valid_wr <= in_data_valid_wr && !discard;
            if (stamp_fire) stamp_cnt <= stamp_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ptp_residence_stamper.sv
// Randomized bench for ptp_residence_stamper against a packet-level model.
module tb_ptp_residence_stamper;
    import ptp_pkt_pkg::*;

    localparam int TICK = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_data_wr = 1'b0;
    logic [FLIT_W-1:0] in_data = '0;
    logic              in_data_valid = 1'b0;
    logic              in_data_valid_wr = 1'b0;
    logic              in_ready;
    logic              out_data_wr;
    logic [FLIT_W-1:0] out_data;
    logic              out_data_valid;
    logic              out_data_valid_wr;
    logic              out_ready = 1'b0;
    logic [47:0]       temp_cnt = '0;
    logic              stamp_en = 1'b0;
    logic [31:0]       stamp_cnt;

    always #5 clk = ~clk;

    ptp_residence_stamper #(.PLATFORM("Xilinx"), .TICK_NS(TICK)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_data_wr        (in_data_wr),
        .in_data           (in_data),
        .in_data_valid     (in_data_valid),
        .in_data_valid_wr  (in_data_valid_wr),
        .in_ready          (in_ready),
        .out_data_wr       (out_data_wr),
        .out_data          (out_data),
        .out_data_valid    (out_data_valid),
        .out_data_valid_wr (out_data_valid_wr),
        .out_ready         (out_ready),
        .temp_cnt          (temp_cnt),
        .stamp_en          (stamp_en),
        .stamp_cnt         (stamp_cnt)
    );

    typedef struct {
        logic [FLIT_W-1:0] data;
        logic              vwr;
        logic              vld;
        int                cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks_total = 0;
    int          checks_pass  = 0;
    int          cyc = 0;
    logic [31:0] model_cnt = '0;
    int          pkt_no = 0;

    task automatic check(input string tag, input logic [FLIT_W-1:0] obs, input logic [FLIT_W-1:0] expv);
        checks_total++;
        if (obs === expv) checks_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, expv);
    endtask

    // correctionField is ns in 48.16 fixed point; result wraps at 64 bits.
    function automatic logic [63:0] ref_corr(input logic [63:0] corr, input logic [47:0] ts,
                                             input logic [47:0] t);
        logic [47:0] d;
        logic [63:0] ns;
        d  = t - ts;
        ns = {16'h0000, d} * 64'(TICK);
        return corr + (ns << 16);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_data_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flit", 134'(out_data_wr), 134'(0));
            end else begin
                e = exp_q.pop_front();
                check("flit", out_data, e.data);
                check("latency", 134'(cyc), 134'(e.cyc));
                check("valid_wr", 134'(out_data_valid_wr), 134'(e.vwr));
                if (e.vwr) check("valid", 134'(out_data_valid), 134'(e.vld));
            end
        end else if (out_data_valid_wr) begin
            check("spurious_valid_wr", 134'(out_data_valid_wr), 134'(0));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_data_wr       = 1'b0;
            in_data_valid_wr = 1'b0;
            rst_n            = 1'b1;
            temp_cnt         = temp_cnt + 48'd1;
        end
    endtask

    task automatic send_pkt(input int len, input logic [15:0] etype, input logic [3:0] msg,
                            input logic [47:0] ts, input logic [63:0] corr, input logic [47:0] t_corr,
                            input bit en, input bit has_tail, input int max_gap, input int rst_at);
        logic [FLIT_W-1:0] f;
        bit   stamp, vld, tail;
        int   guard;
        exp_t e;
        stamp = (len >= 4) && (etype == ETH_TYPE_PTP) && (msg <= MSG_EVENT_MAX) && en &&
                (rst_at < 0 || rst_at > 3);
        vld = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_data_wr = 1'b0;
        out_ready  = ($urandom_range(0, 3) != 0);
        stamp_en   = en;
        #1 check("in_ready", 134'(in_ready), 134'(out_ready));
        guard = 0;
        while (!in_ready) begin
            if (guard == 20) begin
                check("in_ready_timeout", 134'(in_ready), 134'(1));
                break;
            end
            @(negedge clk);
            if (guard >= 2) out_ready = 1'b1;
            guard++;
            #1;
        end
        for (int i = 0; i < len; i++) begin
            idle($urandom_range(0, max_gap));
            tail = (i == len - 1) && has_tail;
            f[127:0]   = {$urandom(), $urandom(), $urandom(), $urandom()};
            f[131:128] = tail ? 4'($urandom_range(0, 15)) : 4'h0;
            f[133:132] = (i == 0) ? FLIT_HEAD : (tail ? FLIT_TAIL : FLIT_MID);
            if (i == 1) f[127:80] = ts;
            if (i == 2) begin
                f[31:16] = etype;
                f[11:8]  = msg;
            end
            if (i == 3) f[79:16] = corr;
            @(negedge clk);
            in_data_wr       = 1'b1;
            in_data          = f;
            in_data_valid_wr = tail;
            in_data_valid    = vld;
            temp_cnt         = (i == 3) ? t_corr : temp_cnt + 48'd1;
            rst_n            = (i != rst_at);
            if (rst_at < 0 || i < rst_at) begin
                e.data = f;
                if (i == 3 && stamp) e.data[79:16] = ref_corr(corr, ts, t_corr);
                e.vwr = tail;
                e.vld = vld;
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            if (i == rst_at) begin
                model_cnt = '0;
                #1;
                check("rst_out_wr", 134'(out_data_wr), 134'(0));
                check("rst_out_data", out_data, 134'(0));
                check("rst_out_vwr", 134'(out_data_valid_wr), 134'(0));
                check("rst_stamp_cnt", 134'(stamp_cnt), 134'(0));
            end
        end
        idle(2);
        if (stamp) model_cnt = model_cnt + 32'd1;
        check("stamp_cnt", 134'(stamp_cnt), 134'(model_cnt));
        $display("pkt %0d len=%0d etype=%h msg=%h en=%0d tail=%0d rst_at=%0d stamped=%0d cnt=%0d",
                 pkt_no, len, etype, msg, en, has_tail, rst_at, stamp, model_cnt);
        pkt_no++;
    endtask

    // Mid and tail flits with no head: must be swallowed entirely.
    task automatic send_stray();
        @(negedge clk);
        in_data_wr = 1'b1;
        in_data    = {FLIT_MID, 4'h0, $urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        in_data          = {FLIT_TAIL, 4'h3, $urandom(), $urandom(), $urandom(), $urandom()};
        in_data_valid_wr = 1'b1;
        in_data_valid    = 1'b1;
        idle(2);
        check("stray_stamp_cnt", 134'(stamp_cnt), 134'(model_cnt));
        $display("stray mid+tail without head cnt=%0d", model_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        logic [47:0] ts, tc;
        #1;
        check("rst_in_ready_lo", 134'(in_ready), 134'(out_ready));
        out_ready = 1'b1;
        #1;
        check("rst_in_ready_hi", 134'(in_ready), 134'(out_ready));
        check("rst_out_wr0", 134'(out_data_wr), 134'(0));
        check("rst_out_data0", out_data, 134'(0));
        check("rst_cnt0", 134'(stamp_cnt), 134'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send_pkt(4, 16'h0800, 4'h0, 48'd500, 64'h1234, 48'd700, 1, 1, 0, -1);
        send_pkt(4, ETH_TYPE_PTP, 4'h0, 48'd1000, 64'h0, 48'd1100, 1, 1, 0, -1);
        send_pkt(5, ETH_TYPE_PTP, 4'h0, 48'hFFFF_FFFF_FFF0, 64'h1_0000, 48'h10, 1, 1, 1, -1);
        send_pkt(5, ETH_TYPE_PTP, 4'h8, 48'd10, 64'h55, 48'd900, 1, 1, 1, -1);
        send_pkt(5, ETH_TYPE_PTP, 4'h0, 48'd10, 64'h55, 48'd900, 0, 1, 1, -1);
        send_pkt(3, ETH_TYPE_PTP, 4'h0, 48'd10, 64'h55, 48'd900, 1, 1, 0, -1);
        send_stray();
        send_pkt(4, ETH_TYPE_PTP, 4'h1, 48'd77, 64'hFFFF_FFFF_FFFF_0000, 48'd99, 1, 1, 2, -1);
        send_pkt(3, ETH_TYPE_PTP, 4'h0, 48'd5, 64'h0, 48'd50, 1, 0, 0, -1);
        send_pkt(6, ETH_TYPE_PTP, 4'h2, 48'd5, 64'h9, 48'd5000, 1, 1, 0, -1);
        send_pkt(6, ETH_TYPE_PTP, 4'h0, 48'd1000, 64'h0, 48'd1100, 1, 1, 0, 3);
        send_pkt(4, ETH_TYPE_PTP, 4'h3, 48'd1000, 64'h0, 48'd1100, 1, 1, 0, -1);

        for (int n = 0; n < 40; n++) begin
            r  = {$urandom(), $urandom()};
            ts = r[47:0];
            r  = {$urandom(), $urandom()};
            tc = ($urandom_range(0, 3) == 0) ? r[47:0] : ts + 48'($urandom_range(0, 100000));
            r  = {$urandom(), $urandom()};
            send_pkt($urandom_range(2, 6),
                     ($urandom_range(0, 3) != 0) ? ETH_TYPE_PTP : 16'h0800,
                     4'($urandom_range(0, 7)), ts, r, tc,
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                     $urandom_range(0, 2), -1);
        end

        idle(3);
        check("drain", 134'(exp_q.size()), 134'(0));
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
